iir_filter_keyed_mc: RTL and testbench
======================================

Name: iir_filter_keyed_mc

Overview:
Parametrised, multi-channel, time-interleaved direct-form-I IIR filter with a built-in key-load FSM, replacing the fixed 32-bit single-channel locked filter. Samples stream over valid/ready. A key register is loaded word-by-word and checked against EXP_KEY. Until the key matches, the filter input is obfuscated by XOR with (EXP_KEY ^ loaded key), so output is wrong. It sits on the core side of the LLKI discrete slave, and the slave drives the key port.

Parameters:
DATA_W, 32, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed Q(COEF_W-FRAC_W).FRAC_W)
FRAC_W, 14, coefficient fraction bits
ORDER, 4, filter order; ORDER+1 b-coefs, ORDER a-coefs (a0 implicit 1)
NUM_CH, 1, interleaved channels, each with private history
KEY_W, 128, key width; multiple of 32
EXP_KEY, 128'h0, expected unlock key

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  input accepted when in_valid&&in_ready
in_data  in  DATA_W  input sample
in_ch  in  max(1,clog2(NUM_CH))  channel of input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  filtered sample
out_ch  out  max(1,clog2(NUM_CH))  channel of out_data
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(2*ORDER+1)  0..ORDER = b0..bORDER; ORDER+1..2*ORDER = a1..aORDER
coef_wdata  in  COEF_W  coefficient value
hist_clr  in  1  one-cycle pulse; zero all channel histories
key_valid  in  1  key word valid
key_ready  out  1  key word accepted when key_valid&&key_ready
key_word  in  32  key word, MSW first
key_clear  in  1  return to LOCKED and zero the key register
key_status  out  2  0 LOCKED, 1 LOADING, 2 UNLOCKED, 3 KEY_ERROR

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ch=0, key_ready=1, key_status=0 (LOCKED). Key register, all history and all coefficients are 0.
- Datapath: x' = in_data ^ (EXP_KEY ^ key_reg)[DATA_W-1:0]. Compute y = (sum bk*x'[n-k] - sum ak*y[n-k]) >>> FRAC_W, arithmetic shift, using a full-width accumulator of DATA_W+COEF_W+clog2(2*ORDER+1) bits.
- Result truncated to DATA_W (wraps) unless IIR_SAT_EN is defined.
- Latency: one output register. A sample accepted in cycle N gives out_valid in cycle N+1.
- in_ready = !out_valid || out_ready. This allows one sample per cycle under continuous out_ready.
- out_data and out_ch hold stable while out_valid && !out_ready.
- History for channel in_ch updates only on an accepted sample; other channels are untouched. in_ch >= NUM_CH: sample is accepted, out_data=0, and no history is updated.
- hist_clr in the same cycle as an accepted sample: the sample is filtered against zero history, and its x'/y become the only non-zero history for that channel.
- coef_we takes effect for samples accepted from the next cycle. Writes while streaming are legal.
- Key FSM:
  - LOCKED: first key word is accepted -> LOADING. The word counter starts at 1.
  - LOADING: each accepted word shifts into key_reg (left shift by 32). When the counter reaches KEY_W/32, key_ready drops for one CHECK cycle.
  - CHECK: key_reg==EXP_KEY -> UNLOCKED, else -> KEY_ERROR.
  - UNLOCKED and KEY_ERROR: key_ready=0 and further words are ignored. Only key_clear or reset leaves these states.
- key_clear has priority over everything in the FSM. It takes effect next cycle: state LOCKED, key_reg=0, counter=0.
- Key state does not gate streaming. Obfuscation depends only on key_reg contents, so a partially loaded key also corrupts output.

Optional Feature:
- Macro IIR_SAT_EN.
- Defined: the shifted accumulator saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and the saturated value is stored in y history.
- Undefined: two's-complement truncation to DATA_W, with the wrapped value stored in history.

Test Plan:
- Reset, EXP_KEY=128'h0, b0=16384 (1.0) and all other coefs 0, stream 5,-7,100 on ch0 with out_ready=1 -> out_data 5,-7,100, each one cycle after acceptance, key_status=0.
- EXP_KEY=128'h0123...CDEF (0x0123456789ABCDEF repeated): load four matching words -> status 1 for 3 words, then 1 CHECK cycle, then 2. Streaming with b0=1.0 passes samples unchanged.
- Same EXP_KEY, load four words of 0 -> status 3, key_ready=0. Input 0 produces out_data = EXP_KEY[31:0]. key_clear then returns status 0.
- NUM_CH=2, b0=a1 coefficients for y=x+0.5y, interleave ch0 impulses 1024 with ch1 zeros -> ch0 gives 1024,512,256, ch1 gives 0,0,0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, no sample lost. hist_clr mid-stream -> next output equals the b0*x term only.
- IIR_SAT_EN defined, b0=1.5, input 0x7FFF_FFF0 -> out_data 0x7FFF_FFFF. Undefined -> out_data is the wrapped negative value.

Source files
------------

// File: rtl/iir_filter_keyed_mc_if.sv
// Sample stream bundle for iir_filter_keyed_mc: input and output valid/ready channels.
interface iir_filter_keyed_mc_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (
    output in_valid, in_data, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/iir_filter_keyed_mc.sv
// Keyed multi-channel direct-form-I IIR; IIR_SAT_EN selects a saturating output instead of wrap.
// Latency 1 cycle (output register); in_ready = !out_valid || out_ready, output holds while stalled.
module iir_filter_keyed_mc #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int ORDER  = 4,
  parameter int NUM_CH = 1,
  parameter int KEY_W  = 128,
  parameter logic [KEY_W-1:0] EXP_KEY = '0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NCOEF = 2*ORDER + 1,
  localparam int CA_W  = $clog2(NCOEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  iir_filter_keyed_mc_if.slave     stream,
  input  logic                     coef_we,
  input  logic [CA_W-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     hist_clr,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [31:0]              key_word,
  input  logic                     key_clear,
  output logic [1:0]               key_status
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NCOEF);
  localparam int NWORDS = KEY_W / 32;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    K_LOCKED,
    K_LOADING,
    K_CHECK,
    K_UNLOCKED,
    K_ERROR
  } key_state_t;

  // ---------------- key FSM ----------------
  key_state_t       state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= K_LOCKED;
      key_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    key_nxt    = key_reg;
    cnt_nxt    = cnt;
    key_ready  = (state == K_LOCKED) || (state == K_LOADING);
    key_fire   = key_valid && key_ready;
    key_status = 2'd0;
    case (state)
      K_LOADING, K_CHECK: key_status = 2'd1;
      K_UNLOCKED:         key_status = 2'd2;
      K_ERROR:            key_status = 2'd3;
      default:            key_status = 2'd0;
    endcase

    if (key_clear) begin
      state_nxt = K_LOCKED;
      key_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        K_LOCKED, K_LOADING: begin
          if (key_fire) begin
            key_nxt   = (key_reg << 32) | KEY_W'(key_word);
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = (cnt_nxt == CNT_W'(NWORDS)) ? K_CHECK : K_LOADING;
          end
        end
        K_CHECK:  state_nxt = (key_reg == EXP_KEY) ? K_UNLOCKED : K_ERROR;
        default:  state_nxt = state;
      endcase
    end
  end

  // ---------------- coefficients ----------------
  logic signed [COEF_W-1:0] coef [NCOEF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else if (coef_we && (int'(coef_addr) < NCOEF)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // ---------------- datapath ----------------
  logic signed [DATA_W-1:0] xh [NUM_CH][ORDER];
  logic signed [DATA_W-1:0] yh [NUM_CH][ORDER];
  logic signed [DATA_W-1:0] xv [ORDER];
  logic signed [DATA_W-1:0] yv [ORDER];
  logic signed [DATA_W-1:0] x_obf, y;
  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic                     ch_ok, in_ready, in_fire;
  logic [CH_W-1:0]          ch_idx;
  logic                     out_valid_r;
  logic [DATA_W-1:0]        out_data_r;
  logic [CH_W-1:0]          out_ch_r;

  assign in_ready = !out_valid_r || stream.out_ready;
  assign in_fire  = stream.in_valid && in_ready;
  assign ch_ok    = (int'(stream.in_ch) < NUM_CH);
  assign ch_idx   = ch_ok ? stream.in_ch : '0;
  // Mask is zero only once key_reg holds EXP_KEY; DATA_W must not exceed KEY_W.
  assign x_obf    = stream.in_data ^ DATA_W'(EXP_KEY ^ key_reg);

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
`endif

  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      xv[k] = hist_clr ? '0 : xh[ch_idx][k];
      yv[k] = hist_clr ? '0 : yh[ch_idx][k];
    end
    acc = ACC_W'(coef[0]) * ACC_W'(x_obf);
    for (int k = 1; k <= ORDER; k++) begin
      acc = acc + ACC_W'(coef[k]) * ACC_W'(xv[k-1])
                - ACC_W'(coef[ORDER+k]) * ACC_W'(yv[k-1]);
    end
    acc_sh = acc >>> FRAC_W;
`ifdef IIR_SAT_EN
    if (acc_sh > Y_MAX)      y = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_sh < Y_MIN) y = {1'b1, {(DATA_W-1){1'b0}}};
    else                     y = DATA_W'(acc_sh);
`else
    y = DATA_W'(acc_sh);
`endif
  end

  // hist_clr zeroes everything first; an accepted sample in the same cycle then seeds its channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          xh[c][k] <= '0;
          yh[c][k] <= '0;
        end
      end
    end else begin
      if (hist_clr) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int k = 0; k < ORDER; k++) begin
            xh[c][k] <= '0;
            yh[c][k] <= '0;
          end
        end
      end
      if (in_fire && ch_ok) begin
        xh[ch_idx][0] <= x_obf;
        yh[ch_idx][0] <= y;
        for (int k = 1; k < ORDER; k++) begin
          xh[ch_idx][k] <= xv[k-1];
          yh[ch_idx][k] <= yv[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (in_fire) begin
      out_valid_r <= 1'b1;
      out_data_r  <= ch_ok ? y : '0;
      out_ch_r    <= stream.in_ch;
    end else if (stream.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign stream.in_ready  = in_ready;
  assign stream.out_valid = out_valid_r;
  assign stream.out_data  = out_data_r;
  assign stream.out_ch    = out_ch_r;

endmodule

// File: tb/tb_iir_filter_keyed_mc.sv
// Scoreboard bench for iir_filter_keyed_mc: three channels, non-zero expected key.
module tb_iir_filter_keyed_mc;
  localparam logic [127:0] KEY = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [31:0]  KLO = 32'h89ABCDEF;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        hist_clr = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [31:0] key_word = '0;
  logic        key_clear = 1'b0;
  logic [1:0]  key_status;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  iir_filter_keyed_mc_if #(.DATA_W(32), .CH_W(2)) bus ();

  iir_filter_keyed_mc #(
    .DATA_W(32), .COEF_W(16), .FRAC_W(14), .ORDER(4),
    .NUM_CH(3), .KEY_W(128), .EXP_KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .stream(bus),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .hist_clr(hist_clr),
    .key_valid(key_valid), .key_ready(key_ready), .key_word(key_word),
    .key_clear(key_clear), .key_status(key_status)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Output monitor: one pop per handshake, sampled on the falling edge before it completes.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h ch %0d required none", bus.out_data, bus.out_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_data !== e.d || bus.out_ch !== e.ch) begin
          errors++;
          $display("FAIL out_sample got %h ch %0d required %h ch %0d",
                   bus.out_data, bus.out_ch, e.d, e.ch);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] ch, input logic [31:0] ed);
    exp_t e;
    e.d = ed;
    e.ch = ch;
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ch    = ch;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [15:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    key_valid = 1'b1; key_word = w;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ch = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b required 0", bus.out_valid); end
    if (bus.out_data !== 32'h0)  begin errors++; $display("FAIL rst_out_data got %h required 0", bus.out_data); end
    if (bus.out_ch !== 2'd0)     begin errors++; $display("FAIL rst_out_ch got %0d required 0", bus.out_ch); end
    if (key_ready !== 1'b1)      begin errors++; $display("FAIL rst_key_ready got %b required 1", key_ready); end
    if (key_status !== 2'd0)     begin errors++; $display("FAIL rst_key_status got %0d required 0", key_status); end
    @(posedge clk); #1;
  endtask

  // Locked with an all-zero key register: the mask is the low word of the expected key.
  task automatic test_locked_obf();
    write_coef(4'd0, 16'd16384);
    send(32'd5, 2'd0, 32'd5 ^ KLO);
    send(-32'sd7, 2'd0, 32'hFFFF_FFF9 ^ KLO);
    drain();
    checks++;
    if (key_status !== 2'd0) begin errors++; $display("FAIL locked_status got %0d required 0", key_status); end
  endtask

  task automatic test_key_error();
    for (int i = 0; i < 4; i++) begin
      load_word(32'h0);
      checks++;
      if (key_status !== 2'd1) begin errors++; $display("FAIL err_load%0d_status got %0d required 1", i, key_status); end
    end
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL err_check_key_ready got %b required 0", key_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (key_status !== 2'd3) begin errors++; $display("FAIL err_status got %0d required 3", key_status); end
    if (key_ready !== 1'b0)  begin errors++; $display("FAIL err_key_ready got %b required 0", key_ready); end
    load_word(KEY[127:96]);
    checks++;
    if (key_status !== 2'd3) begin errors++; $display("FAIL err_sticky got %0d required 3", key_status); end
    send(32'h0, 2'd0, KLO);
    drain();
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    checks += 2;
    if (key_status !== 2'd0) begin errors++; $display("FAIL clear_status got %0d required 0", key_status); end
    if (key_ready !== 1'b1)  begin errors++; $display("FAIL clear_key_ready got %b required 1", key_ready); end
  endtask

  task automatic test_key_unlock();
    logic [31:0] w [4];
    w[0] = KEY[127:96]; w[1] = KEY[95:64]; w[2] = KEY[63:32]; w[3] = KEY[31:0];
    load_word(w[0]);
    // Partial key: mask low word is KLO ^ 0x01234567.
    send(32'h0, 2'd0, 32'h8888_8888);
    drain();
    for (int i = 1; i < 4; i++) begin
      load_word(w[i]);
      checks++;
      if (key_status !== 2'd1) begin errors++; $display("FAIL unl_load%0d_status got %0d required 1", i, key_status); end
    end
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL unl_check_key_ready got %b required 0", key_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (key_status !== 2'd2) begin errors++; $display("FAIL unl_status got %0d required 2", key_status); end
    if (key_ready !== 1'b0)  begin errors++; $display("FAIL unl_key_ready got %b required 0", key_ready); end
    send(32'd5, 2'd0, 32'd5);
    send(-32'sd7, 2'd0, 32'hFFFF_FFF9);
    send(32'd100, 2'd0, 32'd100);
    drain();
  endtask

  // y = x + 0.5*y[n-1]: a1 = -0.5 in Q2.14.
  task automatic test_multichannel();
    write_coef(4'd5, 16'hE000);
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    send(32'd1024, 2'd0, 32'd1024);
    send(32'd0,    2'd1, 32'd0);
    send(32'd0,    2'd0, 32'd512);
    send(32'd0,    2'd1, 32'd0);
    send(32'd0,    2'd0, 32'd256);
    send(32'd0,    2'd1, 32'd0);
    drain();
  endtask

  task automatic test_hist_clr_badch();
    send(32'd0, 2'd0, 32'd128);
    hist_clr = 1'b1;
    send(32'd100, 2'd0, 32'd100);
    hist_clr = 1'b0;
    send(32'd999, 2'd3, 32'd0);
    send(32'd0, 2'd0, 32'd50);
    drain();
  endtask

  task automatic test_backpressure();
    exp_t e;
    write_coef(4'd5, 16'h0000);
    send(32'd200, 2'd1, 32'd200);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd300;
    bus.in_ch     = 2'd2;
    e.d = 32'd300; e.ch = 2'd2;
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.in_ready !== 1'b0)    begin errors++; $display("FAIL bp_in_ready%0d got %b required 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1)   begin errors++; $display("FAIL bp_out_valid%0d got %b required 1", i, bus.out_valid); end
      if (bus.out_data !== 32'd200) begin errors++; $display("FAIL bp_hold%0d got %h required %h", i, bus.out_data, 32'd200); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
  endtask

  // b0 = 1.5 pushes near-full-scale inputs out of range in both directions.
  task automatic test_saturation();
    write_coef(4'd0, 16'd24576);
`ifdef IIR_SAT_EN
    send(32'h7FFF_FFF0, 2'd0, 32'h7FFF_FFFF);
    send(32'h8000_0010, 2'd0, 32'h8000_0000);
`else
    send(32'h7FFF_FFF0, 2'd0, 32'hBFFF_FFE8);
    send(32'h8000_0010, 2'd0, 32'h4000_0018);
`endif
    send(32'd1000, 2'd0, 32'd1500);
    drain();
  endtask

  task automatic test_drained();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drained pending %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_locked_obf();
    test_key_error();
    test_key_unlock();
    test_multichannel();
    test_hist_clr_badch();
    test_backpressure();
    test_saturation();
    test_drained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
